// File: rtl/unconnected_channel_bank_if.sv
`default_nettype none
// ============================================================================
// Module   : unconnected_channel_bank_if
// Brief    : Per-lane valid/ready bus bundle for unconnected_channel_bank.
// Revision : 1.0  initial release
// ============================================================================
interface unconnected_channel_bank_if #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 8,
    parameter int CNT_W  = 16
);
    logic [NUM_CH-1:0]       in_valid;
    logic [NUM_CH-1:0]       in_ready;
    logic [NUM_CH*WIDTH-1:0] in_data;
    logic [NUM_CH-1:0]       out_valid;
    logic [NUM_CH-1:0]       out_ready;
    logic [NUM_CH*WIDTH-1:0] out_data;
    logic [NUM_CH*CNT_W-1:0] xfer_cnt;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, xfer_cnt
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, xfer_cnt
    );
endinterface
`default_nettype wire

// File: rtl/unconnected_channel_bank.sv
`default_nettype none
// ============================================================================
// Module   : unconnected_channel_bank
// Brief    : NUM_CH independent elastic pipelines; masked lanes are left
//            unconnected (write-only shadow input, constant-tied output).
// Revision : 1.0  initial release
// ============================================================================
module unconnected_channel_bank #(
    parameter int                WIDTH      = 8,
    parameter int                NUM_CH     = 4,
    parameter int                DEPTH      = 2,
    parameter logic [NUM_CH-1:0] CH_EN_MASK = '1,
    parameter logic [WIDTH-1:0]  TIE_VALUE  = '0,
    parameter int                CNT_W      = 16
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    unconnected_channel_bank_if.slave bus
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        if (CH_EN_MASK[i]) begin : g_live
            logic [DEPTH-1:0]       w_v;
            logic [DEPTH*WIDTH-1:0] w_dq;
            logic [DEPTH-1:0]       w_rdy;
            logic                   w_pop;
            logic [CNT_W-1:0]       r_cnt;

            for (genvar k = 0; k < DEPTH; k++) begin : g_stage
                logic             r_v;
                logic [WIDTH-1:0] r_d;
                logic             w_up_v;
                logic [WIDTH-1:0] w_up_d;

                // Stage k may load when any stage from k to the tail is empty
                // or the tail is being drained this cycle (bubble collapse).
                assign w_rdy[k] = bus.out_ready[i] | ~(&w_v[DEPTH-1:k]);

                if (k == 0) begin : g_head
                    assign w_up_v = bus.in_valid[i];
                    assign w_up_d = bus.in_data[i*WIDTH +: WIDTH];
                end else begin : g_body
                    assign w_up_v = w_v[k-1];
                    assign w_up_d = w_dq[(k-1)*WIDTH +: WIDTH];
                end

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        r_v <= 1'b0;
                        r_d <= '0;
                    end else if (w_rdy[k]) begin
                        r_v <= w_up_v;
                        if (w_up_v) begin
                            r_d <= w_up_d;
                        end
                    end
                end

                assign w_v[k]                   = r_v;
                assign w_dq[k*WIDTH +: WIDTH]   = r_d;
            end

            assign w_pop = w_v[DEPTH-1] & bus.out_ready[i];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                end else if (w_pop && (r_cnt != {CNT_W{1'b1}})) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign bus.in_ready[i]                   = w_rdy[0];
            assign bus.out_valid[i]                  = w_v[DEPTH-1];
            assign bus.out_data[i*WIDTH +: WIDTH]    = w_dq[(DEPTH-1)*WIDTH +: WIDTH];
            assign bus.xfer_cnt[i*CNT_W +: CNT_W]    = r_cnt;
        end else begin : g_masked
            // Shadow captures the lane's input but deliberately has no reader.
            logic [WIDTH-1:0] r_shadow_unused;
            logic             w_unused_ready;

            assign w_unused_ready = bus.out_ready[i];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_shadow_unused <= '0;
                end else if (bus.in_valid[i]) begin
                    r_shadow_unused <= bus.in_data[i*WIDTH +: WIDTH];
                end
            end

            assign bus.in_ready[i]                   = 1'b1;
            assign bus.out_valid[i]                  = 1'b0;
            assign bus.out_data[i*WIDTH +: WIDTH]    = TIE_VALUE;
            assign bus.xfer_cnt[i*CNT_W +: CNT_W]    = '0;
        end
    end

endmodule
`default_nettype wire
